// File: rtl/mem_loader.sv
// mem_loader: UART-side bus initiator for a 512 x 12-bit program memory.
// Decodes set-address / write-word / read-word command bytes from the
// receiver, drives the memory address/write port, and returns read data
// to the transmitter as two bytes (high nibble first, then low byte).
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   tx_ready             transmitter can accept a byte
//   tx_data, tx_start    byte to send and its one-cycle request
//   addr, wr, wdata      memory address, write enable, write data
//   mem_rdata            memory read data (updated by memory on falling edge)
//   busy                 high whenever a command is in progress
module mem_loader #(
  parameter logic [7:0] CMD_ADDR  = 8'h41,
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ  = 8'h52
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [8:0]  addr,
  output logic        wr,
  output logic [11:0] wdata,
  input  logic [11:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_HI,
    S_A_LO,
    S_D_HI,
    S_D_LO,
    S_WR,
    S_RD,
    S_T_HI,
    S_G_HI,
    S_T_LO,
    S_G_LO
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [DW-1:0] wbuf, wbuf_nx;
  logic [DW-1:0] rbuf, rbuf_nx;
  logic [7:0]    tx_data_nx;
  logic          tx_start_nx;

  assign addr  = ptr;
  assign wdata = wbuf;

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      ptr      <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      wr       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      wbuf     <= wbuf_nx;
      rbuf     <= rbuf_nx;
      tx_data  <= tx_data_nx;
      tx_start <= tx_start_nx;
      wr       <= (state_nx == S_WR);
      busy     <= (state_nx != S_IDLE);
    end
  end

  // Command decode and next-state logic; bytes outside IDLE/A_*/D_* are dropped.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    wbuf_nx     = wbuf;
    rbuf_nx     = rbuf;
    tx_data_nx  = tx_data;
    tx_start_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_ADDR)       state_nx = S_A_HI;
          else if (rx_data == CMD_WRITE) state_nx = S_D_HI;
          else if (rx_data == CMD_READ)  state_nx = S_RD;
        end
      end
      S_A_HI: begin
        if (rx_valid) begin
          ptr_nx   = {rx_data[0], ptr[7:0]};
          state_nx = S_A_LO;
        end
      end
      S_A_LO: begin
        if (rx_valid) begin
          ptr_nx   = {ptr[8], rx_data};
          state_nx = S_IDLE;
        end
      end
      S_D_HI: begin
        if (rx_valid) begin
          wbuf_nx  = {rx_data[3:0], wbuf[7:0]};
          state_nx = S_D_LO;
        end
      end
      S_D_LO: begin
        if (rx_valid) begin
          wbuf_nx  = {wbuf[11:8], rx_data};
          state_nx = S_WR;
        end
      end
      S_WR: begin
        ptr_nx   = ptr + AW'(1);
        state_nx = S_IDLE;
      end
      // Memory refreshed mem_rdata at the falling edge inside this cycle.
      S_RD: begin
        rbuf_nx  = mem_rdata;
        ptr_nx   = ptr + AW'(1);
        state_nx = S_T_HI;
      end
      S_T_HI: begin
        if (tx_ready) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = {4'h0, rbuf[11:8]};
          state_nx    = S_G_HI;
        end
      end
      // Gap covers the transmitter's one-cycle tx_ready deassert latency.
      S_G_HI: state_nx = S_T_LO;
      S_T_LO: begin
        if (tx_ready) begin
          tx_start_nx = 1'b1;
          tx_data_nx  = rbuf[7:0];
          state_nx    = S_G_LO;
        end
      end
      S_G_LO:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: memory model on the falling edge, command-level
// reference model (expected pointer, expected memory image, expected TX bytes).
module tb_mem_loader;

  localparam logic [7:0] C_A = 8'h41;
  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [8:0]  addr;
  logic        wr;
  logic [11:0] wdata;
  logic [11:0] mem_rdata;
  logic        busy;

  logic        ready_force;
  logic        rand_ready;
  logic        rnd_bit;
  logic        rand_gaps;

  logic        pre_en;
  logic [8:0]  pre_a;
  logic [11:0] pre_d;

  logic [11:0] mem [512];
  logic [11:0] exp_mem [512];
  logic [8:0]  exp_ptr;

  int          wr_count = 0;
  logic [8:0]  wr_addr_q;
  logic [11:0] wr_data_q;
  logic [7:0]  obs_tx [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_ready = rand_ready ? rnd_bit : ready_force;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  mem_loader #(
    .CMD_ADDR (C_A),
    .CMD_WRITE(C_W),
    .CMD_READ (C_R)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .addr     (addr),
    .wr       (wr),
    .wdata    (wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Memory: samples on the falling edge, read data registered there too.
  always @(negedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (wr === 1'b1) mem[addr] <= wdata;
    mem_rdata <= mem[addr];
  end

  // Observe write strobes and transmit requests.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_count  <= wr_count + 1;
      wr_addr_q <= addr;
      wr_data_q <= wdata;
    end
    if (tx_start === 1'b1) obs_tx.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap();
    if (rand_gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0 after %0d cycles", tag, busy, n);
    end
  endtask

  task automatic check_addr(input string tag);
    checks++;
    if (addr !== exp_ptr) begin
      errors++;
      $display("FAIL %s_addr: addr=%h required %h", tag, addr, exp_ptr);
    end
  endtask

  task automatic cmd_addr(input logic [8:0] a, input logic junk, input string tag);
    send_byte(C_A); gap();
    send_byte({junk ? 7'($urandom) : 7'h00, a[8]}); gap();
    send_byte(a[7:0]);
    exp_ptr = a;
    check_addr(tag);
  endtask

  task automatic cmd_write(input logic [11:0] d, input logic junk, input string tag);
    int wc0 = wr_count;
    send_byte(C_W); gap();
    send_byte({junk ? 4'($urandom) : 4'h0, d[11:8]}); gap();
    send_byte(d[7:0]);
    wait_idle(tag);
    checks++;
    if (wr_count !== wc0 + 1) begin
      errors++;
      $display("FAIL %s_wr_pulses: got %0d required 1", tag, wr_count - wc0);
    end
    checks++;
    if (wr_addr_q !== exp_ptr) begin
      errors++;
      $display("FAIL %s_wr_addr: got %h required %h", tag, wr_addr_q, exp_ptr);
    end
    checks++;
    if (wr_data_q !== d) begin
      errors++;
      $display("FAIL %s_wr_data: got %h required %h", tag, wr_data_q, d);
    end
    exp_mem[exp_ptr] = d;
    exp_ptr = exp_ptr + 9'd1;
    check_addr(tag);
  endtask

  task automatic check_tx(input int n0, input logic [11:0] v, input string tag);
    checks++;
    if (obs_tx.size() != n0 + 2) begin
      errors++;
      $display("FAIL %s_tx_count: got %0d required 2", tag, obs_tx.size() - n0);
    end
    if (obs_tx.size() >= n0 + 2) begin
      checks++;
      if (obs_tx[n0] !== {4'h0, v[11:8]}) begin
        errors++;
        $display("FAIL %s_tx_hi: got %h required %h", tag, obs_tx[n0], {4'h0, v[11:8]});
      end
      checks++;
      if (obs_tx[n0+1] !== v[7:0]) begin
        errors++;
        $display("FAIL %s_tx_lo: got %h required %h", tag, obs_tx[n0+1], v[7:0]);
      end
    end
  endtask

  task automatic cmd_read(input string tag);
    int n0 = obs_tx.size();
    logic [11:0] v = exp_mem[exp_ptr];
    send_byte(C_R);
    wait_idle(tag);
    check_tx(n0, v, tag);
    exp_ptr = exp_ptr + 9'd1;
    check_addr(tag);
  endtask

  task automatic test_reset();
    logic [11:0] d;
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if (addr !== 9'h000 || wr !== 1'b0 || busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h wr=%b busy=%b tx_start=%b tx_data=%h required 0",
               addr, wr, busy, tx_start, tx_data);
    end
    // Fill memory with random words while held in reset.
    for (int i = 0; i < 512; i++) begin
      d = (i == 8) ? 12'o0001 : 12'($urandom);
      pre_a = 9'(i); pre_d = d; pre_en = 1'b1;
      exp_mem[i] = d;
      tick();
    end
    pre_en = 1'b0;
    rstn = 1'b1;
    exp_ptr = 9'h000;
    tick();
    send_byte(8'h33);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_junk_busy: busy=%b required 0", busy);
    end
    check_addr("idle_junk");
  endtask

  task automatic test_addr_write();
    cmd_addr(9'h10F, 1'b0, "set_addr");
    cmd_write(12'hABC, 1'b0, "write");
    checks++;
    if (mem[271] !== 12'hABC) begin
      errors++;
      $display("FAIL write_mem271: got %h required abc", mem[271]);
    end
    checks++;
    if (addr !== 9'h110) begin
      errors++;
      $display("FAIL write_post_addr: got %h required 110", addr);
    end
  endtask

  task automatic test_readback();
    ready_force = 1'b1;
    cmd_addr(9'h008, 1'b0, "rb_addr");
    cmd_read("readback");
    checks++;
    if (addr !== 9'd9) begin
      errors++;
      $display("FAIL readback_post_addr: got %0d required 9", addr);
    end
  endtask

  task automatic test_wrap();
    cmd_addr(9'h1FF, 1'b0, "wrap_addr");
    cmd_write(12'h700, 1'b0, "wrap");
    checks++;
    if (mem[511] !== 12'h700) begin
      errors++;
      $display("FAIL wrap_mem511: got %h required 700", mem[511]);
    end
    checks++;
    if (addr !== 9'h000) begin
      errors++;
      $display("FAIL wrap_post_addr: got %h required 000", addr);
    end
  endtask

  task automatic test_tx_stall();
    int n0 = obs_tx.size();
    int wc0 = wr_count;
    int busy_low = 0;
    logic [11:0] v = exp_mem[exp_ptr];
    ready_force = 1'b0;
    send_byte(C_R);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) send_byte(C_W);
      else tick();
      if (busy !== 1'b1) busy_low++;
    end
    checks++;
    if (obs_tx.size() != n0) begin
      errors++;
      $display("FAIL stall_no_tx: got %0d pulses required 0", obs_tx.size() - n0);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL stall_busy: busy low in %0d cycles required 0", busy_low);
    end
    ready_force = 1'b1;
    wait_idle("stall");
    check_tx(n0, v, "stall");
    exp_ptr = exp_ptr + 9'd1;
    check_addr("stall");
    tick();
    checks++;
    if (busy !== 1'b0 || wr_count != wc0) begin
      errors++;
      $display("FAIL stall_drop: busy=%b writes=%0d required busy 0 writes 0", busy, wr_count - wc0);
    end
  endtask

  task automatic test_reset_mid_write();
    int wc0 = wr_count;
    send_byte(C_W);
    send_byte(8'h05);
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    exp_ptr = 9'h000;
    repeat (3) tick();
    checks++;
    if (wr_count != wc0) begin
      errors++;
      $display("FAIL midrst_wr: got %0d writes required 0", wr_count - wc0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: busy=%b required 0", busy);
    end
    check_addr("midrst");
  endtask

  task automatic test_random();
    logic [7:0] b;
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: cmd_addr(9'($urandom), 1'b1, "rnd_addr");
        1: cmd_write(12'($urandom), 1'b1, "rnd_write");
        2: cmd_read("rnd_read");
        default: begin
          b = 8'($urandom);
          while (b == C_A || b == C_W || b == C_R) b = 8'($urandom);
          send_byte(b);
          tick();
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rnd_junk: byte %h busy=%b required 0", b, busy);
          end
        end
      endcase
    end
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
  endtask

  task automatic test_back_to_back();
    ready_force = 1'b1;
    cmd_addr(9'h0C3, 1'b1, "b2b_addr");
    cmd_write(12'h5A5, 1'b1, "b2b_write");
    cmd_addr(9'h0C3, 1'b1, "b2b_addr2");
    cmd_read("b2b_read");
  endtask

  initial begin
    rstn        = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    ready_force = 1'b0;
    rand_ready  = 1'b0;
    rand_gaps   = 1'b0;
    pre_en      = 1'b0;
    pre_a       = '0;
    pre_d       = '0;
    exp_ptr     = '0;
    test_reset();
    test_addr_write();
    test_readback();
    test_wrap();
    test_tx_stall();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
